// File: rtl/mod_cnt_chain.sv
// mod_cnt_chain: cascade of per-stage modulo counters (e.g. sec/min/hour).
// Stage i lives at sum[i*BITS +: BITS] and has modulus MAX_LIST[i*BITS +: BITS].
// Stage 0 steps on en. Each higher stage steps when the stage below steps
// out of its terminal value.
// Counting is up or down, and the direction is sampled on every edge.
// Optional feature macro: MOD_CNT_CHAIN_SNAPSHOT_EN adds the snap input and
// the snap_val output. snap_val is a register that captures the pre-update sum.
module mod_cnt_chain #(
  parameter int NUM_STAGES = 3,
  parameter int BITS       = 8,
  parameter logic [NUM_STAGES*BITS-1:0] MAX_LIST = {8'd24, 8'd60, 8'd60}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       up,
  input  logic                       load,
  input  logic [NUM_STAGES*BITS-1:0] load_val,
  output logic [NUM_STAGES*BITS-1:0] sum,
  output logic [NUM_STAGES-1:0]      tc,
  output logic                       wrap
`ifdef MOD_CNT_CHAIN_SNAPSHOT_EN
  ,
  input  logic                       snap,
  output logic [NUM_STAGES*BITS-1:0] snap_val
`endif
);

  // One extra bit so that the +/-1 arithmetic and the compares never overflow.
  localparam int W = BITS + 1;

  logic [BITS-1:0]       r_val  [NUM_STAGES];
  logic [BITS-1:0]       w_next [NUM_STAGES];
  logic [BITS-1:0]       w_load [NUM_STAGES];
  logic [NUM_STAGES-1:0] w_at_term;
  logic [NUM_STAGES-1:0] w_step;
  logic                  r_wrap;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      localparam logic [W-1:0] MAXV = {1'b0, MAX_LIST[gi*BITS +: BITS]};
      localparam logic [BITS-1:0] TOPV = BITS'(MAXV - W'(1));

      if (MAXV < W'(2)) begin : g_bad_mod
        $error("mod_cnt_chain: stage %0d modulus must be >= 2", gi);
      end

      logic [W-1:0] w_cur;
      logic [W-1:0] w_term;
      logic [W-1:0] w_fld;

      assign w_cur  = {1'b0, r_val[gi]};
      // The terminal value is the top value when counting up, and 0 when counting down.
      assign w_term = up ? (MAXV - W'(1)) : '0;
      assign w_at_term[gi] = (w_cur == w_term);

      // Step value: the stage wraps at its terminal value, otherwise it moves by one.
      assign w_next[gi] = w_at_term[gi] ? (up ? '0 : TOPV)
                                        : (up ? BITS'(w_cur + W'(1)) : BITS'(w_cur - W'(1)));

      // A load field that is out of range is cleared instead of being kept.
      assign w_fld      = {1'b0, load_val[gi*BITS +: BITS]};
      assign w_load[gi] = (w_fld < MAXV) ? load_val[gi*BITS +: BITS] : '0;

      assign sum[gi*BITS +: BITS] = r_val[gi];
      assign tc[gi] = w_step[gi] & w_at_term[gi] & ~load & ~reset;
    end
  endgenerate

  // Ripple the step condition through the chain.
  always_comb begin
    w_step = '0;
    w_step[0] = en;
    for (int i = 1; i < NUM_STAGES; i++) begin
      w_step[i] = w_step[i-1] & w_at_term[i-1];
    end
  end

  // Stage registers and wrap pulse. Priority on each edge: reset, then load, then step.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_val[i] <= '0;
      end
      r_wrap <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        r_val[i] <= w_load[i];
      end
      r_wrap <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (w_step[i]) begin
          r_val[i] <= w_next[i];
        end
      end
      r_wrap <= tc[NUM_STAGES-1];
    end
  end

  assign wrap = r_wrap;

`ifdef MOD_CNT_CHAIN_SNAPSHOT_EN
  logic [NUM_STAGES*BITS-1:0] r_snap;

  // Capture the value that is visible during the snap cycle. Reset takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= '0;
    end else if (snap) begin
      r_snap <= sum;
    end
  end

  assign snap_val = r_snap;
`endif

endmodule

// File: tb/tb_mod_cnt_chain.sv
// Testbench for mod_cnt_chain (default 24/60/60 chain).
// The reference model treats the chain as one mixed-radix number.
// Stimulus is a set of directed cases followed by randomized cycles.
// Build with MOD_CNT_CHAIN_SNAPSHOT_EN defined to also check snap_val.
module tb_mod_cnt_chain;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [23:0] load_val;
  logic [23:0] sum;
  logic [2:0]  tc;
  logic        wrap;
  logic        snap_drv;
`ifdef MOD_CNT_CHAIN_SNAPSHOT_EN
  logic [23:0] snap_val;
`endif

  always #5 clk = ~clk;

  mod_cnt_chain #(.NUM_STAGES(3), .BITS(8), .MAX_LIST({8'd24, 8'd60, 8'd60})) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .sum      (sum),
    .tc       (tc),
    .wrap     (wrap)
`ifdef MOD_CNT_CHAIN_SNAPSHOT_EN
    ,
    .snap     (snap_drv),
    .snap_val (snap_val)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          mod_q [3] = '{60, 60, 24};
  int          mv [3];
  logic [2:0]  obs_tc;
  logic [23:0] exp_snap = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] model_sum();
    return 24'(mv[0]) | (24'(mv[1]) << 8) | (24'(mv[2]) << 16);
  endfunction

  // A stage at index i reports tc when en is high and stages 0..i are all at their terminal value.
  function automatic logic [2:0] model_tc(input logic r, input logic l, input logic e, input logic u);
    logic [2:0] res = '0;
    logic all_t = 1'b1;
    if (r || l || !e) return '0;
    for (int i = 0; i < 3; i++) begin
      all_t = all_t && (u ? (mv[i] == mod_q[i] - 1) : (mv[i] == 0));
      res[i] = all_t;
    end
    return res;
  endfunction

  // The whole chain is one number modulo 24*60*60.
  task automatic model_step(input logic u);
    int v = 0, w = 1, p = 1;
    for (int i = 0; i < 3; i++) begin
      v += mv[i] * w;
      w *= mod_q[i];
    end
    p = w;
    v = u ? (v + 1) % p : (v + p - 1) % p;
    for (int i = 0; i < 3; i++) begin
      mv[i] = v % mod_q[i];
      v = v / mod_q[i];
    end
  endtask

  task automatic do_cycle(input logic r, input logic l, input logic [23:0] lv,
                          input logic e, input logic u, input logic s, input string note);
    logic [2:0]  exp_tc;
    logic [23:0] pre;
    logic        exp_wrap;
    @(negedge clk);
    reset = r; load = l; load_val = lv; en = e; up = u; snap_drv = s;
    #1;
    exp_tc = model_tc(r, l, e, u);
    obs_tc = tc;
    check_val({note, ":tc"}, 32'(tc), 32'(exp_tc));
    pre = model_sum();
    @(posedge clk);
    cyc++;
    if (r) begin
      for (int i = 0; i < 3; i++) mv[i] = 0;
      exp_snap = '0;
    end else begin
      if (l) begin
        for (int i = 0; i < 3; i++) begin
          int f = int'((lv >> (8 * i)) & 24'hff);
          mv[i] = (f < mod_q[i]) ? f : 0;
        end
      end else if (e) begin
        model_step(u);
      end
      if (s) exp_snap = pre;
    end
    exp_wrap = exp_tc[2];
    #1;
    check_val({note, ":sum"}, 32'(sum), 32'(model_sum()));
    check_val({note, ":wrap"}, 32'(wrap), 32'(exp_wrap));
`ifdef MOD_CNT_CHAIN_SNAPSHOT_EN
    check_val({note, ":snap"}, 32'(snap_val), 32'(exp_snap));
`endif
    $display("cyc %0d %s rst=%0b ld=%0b en=%0b up=%0b tc=%03b sum=%06h wrap=%0b",
             cyc, note, r, l, e, u, obs_tc, sum, wrap);
  endtask

  initial begin
    logic [23:0] lv;
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; snap_drv = 1'b0;
    for (int i = 0; i < 3; i++) mv[i] = 0;

    // Reset together with en and load. Everything must stay cleared.
    do_cycle(1, 1, 24'h123456, 1, 1, 1, "reset");
    do_cycle(1, 1, 24'h123456, 1, 1, 1, "reset");
    check_val("reset_sum", 32'(sum), 32'h0);

    // Count up for 60 cycles. Stage 0 rolls over into stage 1.
    for (int k = 0; k < 60; k++) begin
      do_cycle(0, 0, '0, 1, 1, 0, "up");
      if (k == 59) check_val("up59_tc", 32'(obs_tc), 32'h1);
    end
    check_val("up60_sum", 32'(sum), 32'h000100);

    // Full wrap when counting up from 23:59:59.
    do_cycle(0, 1, {8'd23, 8'd59, 8'd59}, 0, 1, 0, "ld_top");
    do_cycle(0, 0, '0, 1, 1, 0, "fullwrap");
    check_val("fullwrap_tc", 32'(obs_tc), 32'h7);
    check_val("fullwrap_sum", 32'(sum), 32'h0);
    check_val("fullwrap_pulse", 32'(wrap), 32'h1);
    do_cycle(0, 0, '0, 0, 1, 0, "idle");
    check_val("wrap_once", 32'(wrap), 32'h0);

    // Count down from zero. The chain borrows through every stage.
    do_cycle(0, 0, '0, 1, 0, 0, "down");
    check_val("down_sum", 32'(sum), 32'h173B3B);
    check_val("down_wrap", 32'(wrap), 32'h1);
    do_cycle(0, 0, '0, 1, 0, 0, "down");
    check_val("down2_sum", 32'(sum), 32'h173B3A);

    // Load with out-of-range fields while en is high. The load wins.
    do_cycle(0, 1, {8'd30, 8'd60, 8'd5}, 1, 1, 0, "ld_rng");
    check_val("ld_rng_sum", 32'(sum), 32'h000005);
    for (int k = 0; k < 10; k++) do_cycle(0, 0, '0, 0, 1, 0, "hold");
    check_val("hold_sum", 32'(sum), 32'h000005);

`ifdef MOD_CNT_CHAIN_SNAPSHOT_EN
    do_cycle(0, 1, 24'h010203, 0, 1, 0, "ld_snap");
    do_cycle(0, 0, '0, 1, 1, 1, "snap");
    check_val("snap_val", 32'(snap_val), 32'h010203);
    check_val("snap_sum", 32'(sum), 32'h010204);
    do_cycle(1, 0, '0, 1, 1, 1, "snap_rst");
    check_val("snap_rst", 32'(snap_val), 32'h0);
`endif

    // Randomized cycles. Loads are biased toward the wrap points.
    for (int k = 0; k < 300; k++) begin
      logic r_b, l_b, e_b, u_b, s_b;
      r_b = ($urandom_range(0, 49) == 0);
      l_b = ($urandom_range(0, 9) == 0);
      e_b = ($urandom_range(0, 3) != 0);
      u_b = 1'($urandom_range(0, 1));
      s_b = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       lv = {8'd23, 8'd59, 8'd59};
        1:       lv = 24'h0;
        default: lv = {8'($urandom_range(0, 30)), 8'($urandom_range(0, 70)), 8'($urandom_range(0, 70))};
      endcase
      do_cycle(r_b, l_b, lv, e_b, u_b, s_b, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
